// File: rtl/rf8088_prefetch_queue.sv
// Code prefetch queue: fetches bytes at (CS<<SEG_SHIFT)+IP over a Wishbone-style
// bus and hands them to the execution unit one byte per pop.
module rf8088_prefetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AMSB      = 19,
    parameter int unsigned SEG_SHIFT = 4,
    parameter logic [15:0] RESET_CS  = 16'hFFFF,
    parameter logic [15:0] RESET_IP  = 16'h0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [15:0]                  cs_i,
    input  logic [15:0]                  ip_i,
    input  logic                         pop_i,
    output logic                         q_valid_o,
    output logic [7:0]                   q_byte_o,
    output logic [15:0]                  q_ip_o,
    output logic [$clog2(DEPTH):0]       q_count_o,
    input  logic                         hold_i,
    output logic                         cyc_o,
    output logic                         stb_o,
    output logic                         we_o,
    output logic [AMSB:0]                adr_o,
    input  logic [7:0]                   dat_i,
    input  logic                         ack_i,
    output logic                         busy_o
);

    localparam int unsigned AW = AMSB + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH_WAIT} state_t;

    state_t          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [15:0]     fetch_cs_q, fetch_cs_d;
    logic [15:0]     fetch_ip_q, fetch_ip_d;
    logic [15:0]     head_ip_q, head_ip_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [DEPTH];

    logic            wr_en;
    logic            rd_en;
    logic [AW-1:0]   lin_adr;

    // Next-state, datapath and bus request logic
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        adr_d      = adr_q;
        fetch_cs_d = fetch_cs_q;
        fetch_ip_d = fetch_ip_q;
        head_ip_d  = head_ip_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        lin_adr = AW'((32'(fetch_cs_q) << SEG_SHIFT) + 32'(fetch_ip_q));
        wr_en   = (state_q == FETCH) && ack_i && !flush_i;
        rd_en   = pop_i && (count_q != '0) && !flush_i;

        if (wr_en) begin
            tail_d     = tail_q + PW'(1);
            fetch_ip_d = fetch_ip_q + 16'd1;
        end
        if (rd_en) begin
            head_d    = head_q + PW'(1);
            head_ip_d = head_ip_q + 16'd1;
        end
        count_d = count_q + CW'(wr_en) - CW'(rd_en);

        if (flush_i) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_cs_d = cs_i;
            fetch_ip_d = ip_i;
            head_ip_d  = ip_i;
        end

        unique case (state_q)
            IDLE: begin
                if (!flush_i && !hold_i && (count_q < CW'(DEPTH))) begin
                    state_d = FETCH;
                    cyc_d   = 1'b1;
                    adr_d   = lin_adr;
                end
            end
            FETCH: begin
                if (ack_i) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                end else if (flush_i) begin
                    state_d = FLUSH_WAIT;
                end
            end
            // The bus cycle cannot be aborted; its data is dropped on ack
            FLUSH_WAIT: begin
                if (ack_i) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cyc_q      <= 1'b0;
            adr_q      <= '1;
            fetch_cs_q <= RESET_CS;
            fetch_ip_q <= RESET_IP;
            head_ip_q  <= RESET_IP;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            adr_q      <= adr_d;
            fetch_cs_q <= fetch_cs_d;
            fetch_ip_q <= fetch_ip_d;
            head_ip_q  <= head_ip_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            mem_q[tail_q] <= dat_i;
        end
    end

    assign cyc_o     = cyc_q;
    assign stb_o     = cyc_q;
    assign busy_o    = cyc_q;
    assign we_o      = 1'b0;
    assign adr_o     = adr_q;
    assign q_valid_o = (count_q != '0);
    assign q_count_o = count_q;
    assign q_ip_o    = head_ip_q;
    assign q_byte_o  = mem_q[head_q];

endmodule

// File: tb/tb_rf8088_prefetch_queue.sv
// Directed bench for rf8088_prefetch_queue: inputs driven and outputs sampled
// on the falling clock edge.
module tb_rf8088_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst, flush, pop, hold, ack;
    logic [15:0] cs, ip;
    logic [7:0]  dat;
    logic        q_valid, cyc, stb, we, busy;
    logic [7:0]  q_byte;
    logic [15:0] q_ip;
    logic [2:0]  q_count;
    logic [19:0] adr;

    int checks = 0;
    int errors = 0;

    rf8088_prefetch_queue dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .cs_i(cs), .ip_i(ip),
        .pop_i(pop), .q_valid_o(q_valid), .q_byte_o(q_byte), .q_ip_o(q_ip),
        .q_count_o(q_count), .hold_i(hold), .cyc_o(cyc), .stb_o(stb),
        .we_o(we), .adr_o(adr), .dat_i(dat), .ack_i(ack), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_stb();
        int n = 0;
        while (stb !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("stb_timeout", 32'(stb), 32'd1);
    endtask

    // Wait for a request, check its address, stall `waits` cycles, then ack
    task automatic bus_cycle(input logic [19:0] exp_adr, input logic [7:0] d, input int waits);
        wait_stb();
        check("adr", 32'(adr), 32'(exp_adr));
        for (int i = 0; i < waits; i++) begin
            tick();
            check("stb_held", 32'(stb), 32'd1);
        end
        ack = 1'b1;
        dat = d;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pop = 1'b0; hold = 1'b0; ack = 1'b0;
        cs = '0; ip = '0; dat = '0;
        tick(); tick();
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_stb", 32'(stb), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_adr", 32'(adr), 32'hFFFFF);
        check("rst_valid", 32'(q_valid), 32'd0);
        check("rst_count", 32'(q_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Fill after reset
        rst = 1'b0;
        tick();
        check("first_stb", 32'(stb), 32'd1);
        for (int i = 0; i < 4; i++)
            bus_cycle(20'hFFFF0 + 20'(i), 8'hA0 + 8'(i), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_no_stb", 32'(stb), 32'd0);
        end
        check("full_count", 32'(q_count), 32'd4);
        check("full_byte", 32'(q_byte), 32'hA0);
        check("full_ip", 32'(q_ip), 32'h0000);
        check("full_valid", 32'(q_valid), 32'd1);

        // Pop from full; refetch at FFFF4
        pop = 1'b1;
        tick();
        check("pop1_ip", 32'(q_ip), 32'h0001);
        check("pop1_byte", 32'(q_byte), 32'hA1);
        check("pop1_count", 32'(q_count), 32'd3);
        tick();
        pop = 1'b0;
        check("pop2_ip", 32'(q_ip), 32'h0002);
        check("pop2_byte", 32'(q_byte), 32'hA2);
        check("refetch_stb", 32'(stb), 32'd1);
        check("refetch_adr", 32'(adr), 32'hFFFF4);

        // Flush while a cycle is pending
        flush = 1'b1; cs = 16'h1234; ip = 16'hFFFF;
        tick();
        flush = 1'b0;
        check("fw_stb", 32'(stb), 32'd1);
        check("fw_adr", 32'(adr), 32'hFFFF4);
        check("fw_count", 32'(q_count), 32'd0);
        check("fw_ip", 32'(q_ip), 32'hFFFF);
        tick(); check("fw_stb2", 32'(stb), 32'd1);
        tick(); check("fw_stb3", 32'(stb), 32'd1);
        ack = 1'b1; dat = 8'hEE;
        tick();
        ack = 1'b0;
        check("fw_drop_stb", 32'(stb), 32'd0);
        check("fw_drop_count", 32'(q_count), 32'd0);
        bus_cycle(20'h2233F, 8'h11, 0);
        check("nf1_count", 32'(q_count), 32'd1);
        check("nf1_byte", 32'(q_byte), 32'h11);
        check("nf1_ip", 32'(q_ip), 32'hFFFF);
        bus_cycle(20'h12340, 8'h22, 0);
        check("nf2_count", 32'(q_count), 32'd2);

        // Simultaneous ack and pop at count 2
        wait_stb();
        check("ap_adr", 32'(adr), 32'h12341);
        ack = 1'b1; dat = 8'h33; pop = 1'b1;
        tick();
        ack = 1'b0;
        check("ap_count", 32'(q_count), 32'd2);
        check("ap_byte", 32'(q_byte), 32'h22);
        check("ap_ip", 32'(q_ip), 32'h0000);
        tick();
        pop = 1'b0;
        check("ap2_byte", 32'(q_byte), 32'h33);
        check("ap2_ip", 32'(q_ip), 32'h0001);
        check("ap2_count", 32'(q_count), 32'd1);
        check("ap2_adr", 32'(adr), 32'h12342);

        // Flush, ack and pop in the same cycle
        flush = 1'b1; ack = 1'b1; pop = 1'b1; dat = 8'h55; cs = 16'h0000; ip = 16'h0100;
        tick();
        flush = 1'b0; ack = 1'b0; pop = 1'b0;
        check("fap_valid", 32'(q_valid), 32'd0);
        check("fap_count", 32'(q_count), 32'd0);
        check("fap_stb", 32'(stb), 32'd0);
        check("fap_ip", 32'(q_ip), 32'h0100);
        tick();
        check("fap_restart_stb", 32'(stb), 32'd1);
        check("fap_restart_adr", 32'(adr), 32'h00100);

        // hold_i in IDLE blocks; hold_i in FETCH does not abort
        bus_cycle(20'h00100, 8'h66, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_idle_stb", 32'(cyc), 32'd0);
        end
        hold = 1'b0;
        tick();
        check("hold_rel_stb", 32'(stb), 32'd1);
        check("hold_rel_adr", 32'(adr), 32'h00101);
        hold = 1'b1;
        bus_cycle(20'h00101, 8'h77, 1);
        check("hold_fetch_count", 32'(q_count), 32'd2);
        tick();
        check("hold_after_stb", 32'(stb), 32'd0);
        hold = 1'b0;
        tick();
        check("hold_resume_stb", 32'(stb), 32'd1);
        check("hold_resume_adr", 32'(adr), 32'h00102);
        check("hold_head_byte", 32'(q_byte), 32'h66);

        // Reset mid-cycle drops the bus immediately
        rst = 1'b1;
        tick();
        check("mrst_stb", 32'(stb), 32'd0);
        check("mrst_adr", 32'(adr), 32'hFFFFF);
        check("mrst_count", 32'(q_count), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
